// File: rtl/jk_stim_gen.sv
// Excitation generator for a bank of JK flip-flops: queues target words, drives
// one-cycle J/K commands toward each target and verifies the bank's Q feedback.
module jk_stim_gen #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int USE_TOGGLE = 0
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  input  logic             CLR_ERR,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             EN,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, CHECK = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] shadow_r, shadow_s;
  logic [WIDTH-1:0] head_s, j_s, k_s;
  logic             en_s, done_s, err_s;
  logic             full_s, empty_s, push_s, pop_s;

  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    if (USE_TOGGLE != 0) excite_j = s ^ t;
    else                 excite_j = ~s & t;
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    if (USE_TOGGLE != 0) excite_k = s ^ t;
    else                 excite_k = s & ~t;
  endfunction

  assign full_s   = (count_r == FULL_CNT);
  assign empty_s  = (count_r == {(AW+1){1'b0}});
  assign IN_READY = !full_s;
  assign push_s   = IN_VALID && !full_s;
  assign pop_s    = (state_r == IDLE) && !empty_s;
  assign head_s   = mem_r[rd_ptr_r];
  assign BUSY     = (state_r != IDLE) || !empty_s;

  // Next-state and next-output decode; ERR set has priority over CLR_ERR.
  always_comb begin
    state_s  = state_r;
    j_s      = {WIDTH{1'b0}};
    k_s      = {WIDTH{1'b0}};
    en_s     = 1'b0;
    done_s   = 1'b0;
    shadow_s = shadow_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          j_s      = excite_j(shadow_r, head_s);
          k_s      = excite_k(shadow_r, head_s);
          en_s     = 1'b1;
          shadow_s = head_s;
          state_s  = DRIVE;
        end else begin
          state_s  = IDLE;
        end
      end
      DRIVE:   state_s = CHECK;
      CHECK: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
    if ((state_r == CHECK) && (Q_FB != shadow_r)) err_s = 1'b1;
    else if (CLR_ERR)                             err_s = 1'b0;
    else                                          err_s = ERR;
  end

  // Control state and registered bank commands.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_r  <= IDLE;
      shadow_r <= {WIDTH{1'b0}};
      J        <= {WIDTH{1'b0}};
      K        <= {WIDTH{1'b0}};
      EN       <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_r  <= state_s;
      shadow_r <= shadow_s;
      J        <= j_s;
      K        <= k_s;
      EN       <= en_s;
      DONE     <= done_s;
      ERR      <= err_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      else        rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge CLK) begin
    if (push_s) mem_r[wr_ptr_r] <= IN_DATA;
  end

endmodule

// File: tb/tb_jk_stim_gen.sv
// Bench for jk_stim_gen: set/reset and toggle instances share stimulus, each drives
// its own JK bank model, and a transaction-level reference predicts every output.
module tb_jk_stim_gen;
  localparam int W = 4;
  localparam int D = 4;

  logic CLK = 1'b0, RSTB = 1'b0, IN_VALID = 1'b0, CLR_ERR = 1'b0;
  logic [W-1:0] IN_DATA = '0, mask = '0;
  logic [W-1:0] bq0, bq1, qfb0, qfb1, j0, k0, j1, k1;
  logic rdy0, rdy1, en0, en1, dn0, dn1, er0, er1, bz0, bz1;
  int n_checks = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  assign qfb0 = bq0 & ~mask;
  assign qfb1 = bq1 & ~mask;

  jk_stim_gen #(.WIDTH(W), .DEPTH(D), .USE_TOGGLE(0)) dut0 (
    .CLK(CLK), .RSTB(RSTB), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(rdy0),
    .CLR_ERR(CLR_ERR), .Q_FB(qfb0), .J(j0), .K(k0), .EN(en0), .DONE(dn0), .ERR(er0), .BUSY(bz0));
  jk_stim_gen #(.WIDTH(W), .DEPTH(D), .USE_TOGGLE(1)) dut1 (
    .CLK(CLK), .RSTB(RSTB), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(rdy1),
    .CLR_ERR(CLR_ERR), .Q_FB(qfb1), .J(j1), .K(k1), .EN(en1), .DONE(dn1), .ERR(er1), .BUSY(bz1));

  // The driven JK banks: Q+ = J&~Q | ~K&Q, cleared with the generator.
  always @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      bq0 <= '0;
      bq1 <= '0;
    end else begin
      bq0 <= (j0 & ~bq0) | (~k0 & bq0);
      bq1 <= (j1 & ~bq1) | (~k1 & bq1);
    end
  end

  // Reference: a queue of targets, a cycles-remaining counter per word, and the
  // excitation derived directly from the old and new target values.
  logic [W-1:0] m_q[$];
  int m_busy = 0;
  logic [W-1:0] m_sh = '0, m_done_tgt = '0, m_t;
  logic [W-1:0] e_j0 = '0, e_k0 = '0, e_j1 = '0, e_k1 = '0;
  logic e_en = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_ready = 1'b1;
  bit m_chk, m_pop, m_acc;

  always @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      m_q.delete();
      m_busy = 0; m_sh = '0; m_done_tgt = '0;
      e_j0 = '0; e_k0 = '0; e_j1 = '0; e_k1 = '0;
      e_en = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    end else begin
      m_chk = (m_busy == 1);
      m_pop = (m_busy == 0) && (m_q.size() > 0);
      m_acc = IN_VALID && (m_q.size() < D);
      e_done = m_chk;
      m_done_tgt = m_sh;
      if (m_chk && ((m_sh & mask) != '0)) e_err = 1'b1;
      else if (CLR_ERR) e_err = 1'b0;
      if (m_busy > 0) m_busy--;
      if (m_pop) begin
        m_t = m_q.pop_front();
        e_j0 = ~m_sh & m_t; e_k0 = m_sh & ~m_t;
        e_j1 = m_sh ^ m_t;  e_k1 = m_sh ^ m_t;
        m_sh = m_t; m_busy = 2; e_en = 1'b1;
      end else begin
        e_j0 = '0; e_k0 = '0; e_j1 = '0; e_k1 = '0; e_en = 1'b0;
      end
      if (m_acc) m_q.push_back(IN_DATA);
      e_busy = (m_busy != 0) || (m_q.size() != 0);
      e_ready = (m_q.size() < D);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge CLK) begin
    if (RSTB) begin
      check("j0", j0, e_j0);       check("k0", k0, e_k0);
      check("j1", j1, e_j1);       check("k1", k1, e_k1);
      check("en0", en0, e_en);     check("en1", en1, e_en);
      check("done0", dn0, e_done); check("done1", dn1, e_done);
      check("err0", er0, e_err);   check("err1", er1, e_err);
      check("busy0", bz0, e_busy); check("busy1", bz1, e_busy);
      check("ready0", rdy0, e_ready); check("ready1", rdy1, e_ready);
      if (e_done) begin
        check("bank0", bq0, m_done_tgt);
        check("bank1", bq1, m_done_tgt);
      end
    end
  end

  // Push one word from IDLE/empty and pin the expected excitation and result.
  task automatic push_word(input logic [W-1:0] d, input logic [W-1:0] xj0, input logic [W-1:0] xk0,
                           input logic [W-1:0] xj1, input logic [W-1:0] xk1, input logic xerr);
    IN_VALID = 1'b1; IN_DATA = d;
    @(negedge CLK); IN_VALID = 1'b0;
    @(negedge CLK);
    check("lit_en", en0, 1'b1);
    check("lit_j0", j0, xj0); check("lit_k0", k0, xk0);
    check("lit_j1", j1, xj1); check("lit_k1", k1, xk1);
    @(negedge CLK);
    check("lit_en_off", en0, 1'b0);
    @(negedge CLK);
    check("lit_done", dn0, 1'b1);
    check("lit_q0", bq0, d); check("lit_q1", bq1, d);
    check("lit_err", er0, xerr);
  endtask

  int cnt;
  bit rdy, saw_full;

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_j", j0, 4'b0000); check("rst_en", en0, 1'b0); check("rst_done", dn0, 1'b0);
    check("rst_err", er0, 1'b0); check("rst_busy", bz0, 1'b0); check("rst_ready", rdy0, 1'b1);
    RSTB = 1'b1;
    @(negedge CLK);

    push_word(4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 1'b0);
    push_word(4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 1'b0);
    push_word(4'b0101, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 1'b0);
    mask = 4'b0001;
    push_word(4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    mask = 4'b0000;
    push_word(4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1);
    CLR_ERR = 1'b1;
    @(negedge CLK); CLR_ERR = 1'b0;
    check("clr_err", er0, 1'b0);
    CLR_ERR = 1'b1; mask = 4'b0001;
    push_word(4'b1111, 4'b1100, 4'b0000, 4'b1100, 4'b1100, 1'b1);
    CLR_ERR = 1'b0; mask = 4'b0000;
    @(negedge CLK);

    // Back-to-back pushes with IN_VALID held until the FIFO fills.
    cnt = 1; saw_full = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rdy = rdy0;
      IN_DATA = W'(cnt);
      @(negedge CLK);
      if (rdy) cnt++;
      if (!rdy0) saw_full = 1'b1;
    end
    IN_VALID = 1'b0;
    check("full_seen", saw_full, 1'b1);
    repeat (20) @(negedge CLK);
    check("drained", bz0, 1'b0);

    // Async reset while in DRIVE with two words still queued.
    IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_DATA = W'(4'b1000 + i);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("pre_rst_en", en0, 1'b1);
    #1 RSTB = 1'b0;
    #1;
    check("arst_j", j0, 4'b0000); check("arst_k", k0, 4'b0000);
    check("arst_en", en0, 1'b0);  check("arst_busy", bz0, 1'b0);
    check("arst_ready", rdy0, 1'b1);
    @(negedge CLK); RSTB = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("post_rst_done", dn0, 1'b0);
      check("post_rst_ready", rdy0, 1'b1);
    end

    // Randomized traffic with occasional clears and injected feedback faults.
    for (int i = 0; i < 2000; i++) begin
      IN_VALID = ($urandom_range(0, 2) != 0);
      IN_DATA  = W'($urandom);
      CLR_ERR  = ($urandom_range(0, 15) == 0);
      mask     = ($urandom_range(0, 9) == 0) ? W'($urandom) : 4'b0000;
      @(negedge CLK);
    end
    IN_VALID = 1'b0; CLR_ERR = 1'b0; mask = 4'b0000;
    repeat (20) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
